// File: rtl/taxi_pkg.sv
// ============================================================================
// taxi_pkg : shared taxi-meter types and default periods          rev 1.0
// ============================================================================
`default_nettype none

package taxi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } wait_state_t;

  localparam logic [31:0] DEFAULT_TICK_CYCLES  = 32'd300_000_000;
  localparam int unsigned DEFAULT_CHARGE_UNITS = 10;

endpackage

`default_nettype wire

// File: rtl/wait_accumulator_if.sv
// ============================================================================
// wait_accumulator_if : control and result bundle of the waiting meter  rev 1.0
// ============================================================================
`default_nettype none

interface wait_accumulator_if #(
  parameter int unsigned DW = 32
);

  logic          enable;
  logic          clear;
  logic [DW-1:0] duration;
  logic          unit_pulse;
  logic          charge_pulse;
  logic          saturated;

  modport master (
    output enable, clear,
    input  duration, unit_pulse, charge_pulse, saturated
  );

  modport slave (
    input  enable, clear,
    output duration, unit_pulse, charge_pulse, saturated
  );

endinterface

`default_nettype wire

// File: rtl/wait_prescaler.sv
// ============================================================================
// wait_prescaler : enabled-cycle divider producing one tick per waiting unit  rev 1.0
// ============================================================================
`default_nettype none

module wait_prescaler
  import taxi_pkg::*;
#(
  parameter int unsigned     PW          = 32,
  parameter logic [PW-1:0]   TICK_CYCLES = PW'(DEFAULT_TICK_CYCLES),
  parameter bit              RESUME      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold_clear,
  input  logic clear,
  output logic tick
);

  localparam logic [PW-1:0] TICK_LAST = TICK_CYCLES - PW'(1);

  logic [PW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == TICK_LAST);
  // A clear on the wrap edge swallows the tick.
  assign tick      = run && !clear && w_at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= w_at_last ? '0 : r_count + PW'(1);
    end else if (hold_clear && !RESUME) begin
      r_count <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wait_accumulator.sv
// ============================================================================
// wait_accumulator : waiting-time units, charge pulses and saturation   rev 1.0
// ============================================================================
`default_nettype none

module wait_accumulator
  import taxi_pkg::*;
#(
  parameter int unsigned   DW           = 32,
  parameter int unsigned   PW           = 32,
  parameter logic [PW-1:0] TICK_CYCLES  = PW'(DEFAULT_TICK_CYCLES),
  parameter logic [DW-1:0] CHARGE_UNITS = DW'(DEFAULT_CHARGE_UNITS),
  parameter logic [DW-1:0] MAX_UNITS    = {DW{1'b1}},
  parameter bit            RESUME       = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  wait_accumulator_if.slave bus
);

  localparam logic [1:0]    ST_IDLE     = IDLE;
  localparam logic [1:0]    ST_COUNT    = COUNT;
  localparam logic [1:0]    ST_HOLD     = HOLD;
  localparam logic [DW-1:0] CHARGE_LAST = CHARGE_UNITS - DW'(1);

  logic [1:0]    r_state;
  logic [DW-1:0] r_duration;
  logic [DW-1:0] r_charge_cnt;
  logic          r_unit_pulse;
  logic          r_charge_pulse;
  logic          r_saturated;

  logic          w_tick;
  logic          w_hold_clear;
  logic          w_inc;
  logic          w_charge_wrap;
  logic [DW-1:0] w_duration_next;

  // Only the first cycle after counting stops may discard the partial interval.
  assign w_hold_clear = (r_state == ST_COUNT) && !bus.enable;

  wait_prescaler #(
    .PW          (PW),
    .TICK_CYCLES (TICK_CYCLES),
    .RESUME      (RESUME)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (bus.enable),
    .hold_clear (w_hold_clear),
    .clear      (bus.clear),
    .tick       (w_tick)
  );

  assign w_inc           = w_tick && (r_duration != MAX_UNITS);
  assign w_charge_wrap   = (r_charge_cnt == CHARGE_LAST);
  assign w_duration_next = r_duration + DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (bus.clear) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.enable)  r_state <= ST_COUNT;
        ST_COUNT: if (!bus.enable) r_state <= ST_HOLD;
        ST_HOLD:  if (bus.enable)  r_state <= ST_COUNT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duration     <= '0;
      r_charge_cnt   <= '0;
      r_unit_pulse   <= 1'b0;
      r_charge_pulse <= 1'b0;
      r_saturated    <= 1'b0;
    end else if (bus.clear) begin
      r_duration     <= '0;
      r_charge_cnt   <= '0;
      r_unit_pulse   <= 1'b0;
      r_charge_pulse <= 1'b0;
      r_saturated    <= 1'b0;
    end else begin
      r_unit_pulse   <= w_inc;
      r_charge_pulse <= w_inc && w_charge_wrap;
      if (w_inc) begin
        r_duration   <= w_duration_next;
        r_charge_cnt <= w_charge_wrap ? '0 : r_charge_cnt + DW'(1);
        r_saturated  <= (w_duration_next == MAX_UNITS);
      end
    end
  end

  assign bus.duration     = r_duration;
  assign bus.unit_pulse   = r_unit_pulse;
  assign bus.charge_pulse = r_charge_pulse;
  assign bus.saturated    = r_saturated;

endmodule

`default_nettype wire
